// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencer: mode encoding and
// controller FSM states.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'd0;
  localparam mode_t MODE_GRAY  = 2'd1;
  localparam mode_t MODE_SCAN  = 2'd2;
  localparam mode_t MODE_BLINK = 2'd3;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/led_pwm.sv
// Brightness PWM: free-running counter compared against the applied level.
// Full-scale brightness forces the gate on so 100% duty is reachable.
module led_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] bright_i,
  output logic                gate_o
);

  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt_q;

  // free-running duty-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + CNT_ONE;
    end
  end

  assign gate_o = (bright_i == CNT_MAX) || (pwm_cnt_q < bright_i);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: prescaled step tick, pattern generator, request FSM
// that only applies new mode/brightness on a tick, and PWM-gated output.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = 5,
  parameter int LOG2DELAY = 22,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_valid,
  output logic                mode_ready,
  input  logic [1:0]          mode_data,
  input  logic [PWM_BITS-1:0] bright_data,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_tick,
  output logic [1:0]          cur_mode
);

  localparam int SCAN_W = $clog2(NUM_LEDS);

  localparam logic [LOG2DELAY-1:0] PRESC_ONE = LOG2DELAY'(1);
  localparam logic [LOG2DELAY-1:0] PRESC_MAX = {LOG2DELAY{1'b1}};
  localparam logic [NUM_LEDS-1:0]  STEP_ONE  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0]  MSB_ONE   = {1'b1, {(NUM_LEDS-1){1'b0}}};
  localparam logic [SCAN_W-1:0]    SCAN_ONE  = SCAN_W'(1);
  localparam logic [SCAN_W-1:0]    SCAN_LAST = SCAN_W'(NUM_LEDS - 1);

  logic [LOG2DELAY-1:0] presc_q;
  logic                 step_tick_q;
  logic [NUM_LEDS-1:0]  step_q;
  logic [NUM_LEDS-1:0]  step_d;
  logic [SCAN_W-1:0]    scan_idx_q;
  logic [SCAN_W-1:0]    scan_idx_d;
  state_t               state_q;
  logic                 mode_ready_q;
  mode_t                pend_mode_q;
  logic [PWM_BITS-1:0]  pend_bright_q;
  mode_t                cur_mode_q;
  logic [PWM_BITS-1:0]  bright_q;
  logic [NUM_LEDS-1:0]  pattern_d;
  logic [NUM_LEDS-1:0]  leds_q;
  logic                 gate_s;

  // prescaler; tick is registered so it lands the cycle after all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      step_tick_q <= 1'b0;
    end else begin
      presc_q     <= presc_q + PRESC_ONE;
      step_tick_q <= (presc_q == PRESC_MAX);
    end
  end

  // normal per-tick advance of the step counters
  always_comb begin
    step_d     = step_q;
    scan_idx_d = scan_idx_q;
    if (step_tick_q) begin
      step_d = step_q + STEP_ONE;
      if (scan_idx_q == SCAN_LAST) begin
        scan_idx_d = '0;
      end else begin
        scan_idx_d = scan_idx_q + SCAN_ONE;
      end
    end else begin
      step_d     = step_q;
      scan_idx_d = scan_idx_q;
    end
  end

  // request FSM; an apply in PEND overrides the normal counter advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      mode_ready_q  <= 1'b0;
      pend_mode_q   <= MODE_OFF;
      pend_bright_q <= '0;
      cur_mode_q    <= MODE_OFF;
      bright_q      <= '0;
      step_q        <= '0;
      scan_idx_q    <= '0;
    end else begin
      step_q     <= step_d;
      scan_idx_q <= scan_idx_d;
      case (state_q)
        RUN: begin
          mode_ready_q <= 1'b1;
          if (mode_valid && mode_ready_q) begin
            pend_mode_q   <= mode_t'(mode_data);
            pend_bright_q <= bright_data;
            mode_ready_q  <= 1'b0;
            state_q       <= PEND;
          end
        end
        PEND: begin
          mode_ready_q <= 1'b0;
          if (step_tick_q) begin
            cur_mode_q   <= pend_mode_q;
            bright_q     <= pend_bright_q;
            step_q       <= '0;
            scan_idx_q   <= '0;
            mode_ready_q <= 1'b1;
            state_q      <= RUN;
          end
        end
        default: begin
          mode_ready_q <= 1'b0;
          state_q      <= RUN;
        end
      endcase
    end
  end

  // pattern from applied mode and counters
  always_comb begin
    pattern_d = '0;
    case (cur_mode_q)
      MODE_OFF:   pattern_d = '0;
      MODE_GRAY:  pattern_d = step_q ^ (step_q >> 1);
      MODE_SCAN:  pattern_d = MSB_ONE >> scan_idx_q;
      MODE_BLINK: pattern_d = step_q[0] ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
      default:    pattern_d = '0;
    endcase
  end

  led_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .bright_i (bright_q),
    .gate_o   (gate_s)
  );

  // registered pad drive
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
    end else begin
      leds_q <= pattern_d & {NUM_LEDS{gate_s}};
    end
  end

  assign leds       = leds_q;
  assign step_tick  = step_tick_q;
  assign cur_mode   = cur_mode_q;
  assign mode_ready = mode_ready_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with an 8-cycle step tick; n counts rising
// edges since rst went low and all expectations are keyed to it.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_valid;
  logic       mode_ready;
  logic [1:0] mode_data;
  logic [3:0] bright_data;
  logic [4:0] leds;
  logic       step_tick;
  logic [1:0] cur_mode;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int highs = 0;
  int nz    = 0;

  led_seq_ctrl #(
    .NUM_LEDS  (5),
    .LOG2DELAY (3),
    .PWM_BITS  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_valid  (mode_valid),
    .mode_ready  (mode_ready),
    .mode_data   (mode_data),
    .bright_data (bright_data),
    .leds        (leds),
    .step_tick   (step_tick),
    .cur_mode    (cur_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) adv();
  endtask

  task automatic req(input logic [1:0] m, input logic [3:0] b);
    mode_valid  = 1'b1;
    mode_data   = m;
    bright_data = b;
  endtask

  initial begin
    rst = 1'b1; mode_valid = 1'b0; mode_data = 2'd0; bright_data = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_mode", 32'(cur_mode), 32'd0);
    chk("rst_ready", 32'(mode_ready), 32'd0);
    chk("rst_tick", 32'(step_tick), 32'd0);
    rst = 1'b0;
    n = 0;

    adv();
    chk("ready_rise", 32'(mode_ready), 32'd1);
    run_to(7);  chk("tick_pre", 32'(step_tick), 32'd0);
    run_to(8);  chk("tick_first", 32'(step_tick), 32'd1);
    run_to(9);  chk("tick_one_cycle", 32'(step_tick), 32'd0);

    // GRAY, full brightness
    req(2'd1, 4'd15);
    run_to(10); chk("gray_acc_ready", 32'(mode_ready), 32'd0);
    mode_valid = 1'b0;
    run_to(16); chk("gray_pend_mode", 32'(cur_mode), 32'd0);
    chk("gray_pend_ready", 32'(mode_ready), 32'd0);
    chk("tick_second", 32'(step_tick), 32'd1);
    run_to(17); chk("gray_applied", 32'(cur_mode), 32'd1);
    chk("gray_ready_back", 32'(mode_ready), 32'd1);
    run_to(18);  chk("gray_s0", 32'(leds), 32'b00000);
    run_to(26);  chk("gray_s1", 32'(leds), 32'b00001);
    run_to(34);  chk("gray_s2", 32'(leds), 32'b00011);
    run_to(42);  chk("gray_s3", 32'(leds), 32'b00010);
    run_to(50);  chk("gray_s4", 32'(leds), 32'b00110);
    run_to(266); chk("gray_s31", 32'(leds), 32'b10000);
    run_to(274); chk("gray_wrap", 32'(leds), 32'b00000);

    // SCAN, full brightness
    req(2'd2, 4'd15);
    run_to(275); mode_valid = 1'b0;
    run_to(282); chk("scan_0", 32'(leds), 32'b10000);
    run_to(290); chk("scan_1", 32'(leds), 32'b01000);
    run_to(298); chk("scan_2", 32'(leds), 32'b00100);
    run_to(306); chk("scan_3", 32'(leds), 32'b00010);
    run_to(314); chk("scan_4", 32'(leds), 32'b00001);
    run_to(322); chk("scan_wrap", 32'(leds), 32'b10000);

    // BLINK, brightness 4: applied at edge 329, pwm count before edge n is (n-1)%16
    req(2'd3, 4'd4);
    run_to(323); mode_valid = 1'b0;
    run_to(330); chk("blink_mode", 32'(cur_mode), 32'd3);
    highs = 0;
    for (int k = 331; k <= 361; k++) begin
      adv();
      chk("blink_pwm", 32'(leds),
          ((((n - 330) / 8) % 2 == 1) && (((n - 1) % 16) < 4)) ? 32'b11111 : 32'b00000);
      if (leds != 5'b00000) highs++;
    end
    chk("blink_high_cnt", 32'(highs), 32'd6);

    // BLINK, brightness 0: never lit
    req(2'd3, 4'd0);
    run_to(363); mode_valid = 1'b0;
    run_to(370);
    nz = 0;
    for (int k = 371; k <= 400; k++) begin
      adv();
      if (leds != 5'b00000) nz++;
    end
    chk("bright0_dark", 32'(nz), 32'd0);

    // BLINK, brightness 15: solid while step is odd
    run_to(401);
    req(2'd3, 4'd15);
    run_to(402); mode_valid = 1'b0;
    run_to(417); chk("b15_even", 32'(leds), 32'b00000);
    for (int k = 418; k <= 424; k++) begin
      adv();
      chk("b15_solid", 32'(leds), 32'b11111);
    end

    // handshake coincident with a tick, then a held request during PEND
    chk("coinc_tick", 32'(step_tick), 32'd1);
    req(2'd1, 4'd15);
    run_to(425); chk("coinc_old_led", 32'(leds), 32'b11111);
    chk("coinc_ready", 32'(mode_ready), 32'd0);
    req(2'd2, 4'd15);
    run_to(426); chk("coinc_old_adv", 32'(leds), 32'b00000);
    run_to(432); chk("coinc_not_yet", 32'(cur_mode), 32'd3);
    run_to(433); chk("coinc_applied", 32'(cur_mode), 32'd1);
    chk("held_ready_back", 32'(mode_ready), 32'd1);
    run_to(434); chk("held_accepted", 32'(mode_ready), 32'd0);
    mode_valid = 1'b0;
    run_to(440); chk("held_pend_mode", 32'(cur_mode), 32'd1);
    run_to(441); chk("held_applied", 32'(cur_mode), 32'd2);
    run_to(442); chk("held_scan0", 32'(leds), 32'b10000);

    // reset while a request is pending
    req(2'd1, 4'd15);
    run_to(443); chk("pend_before_rst", 32'(mode_ready), 32'd0);
    mode_valid = 1'b0;
    rst = 1'b1;
    adv();
    chk("rst2_leds", 32'(leds), 32'd0);
    chk("rst2_mode", 32'(cur_mode), 32'd0);
    chk("rst2_ready", 32'(mode_ready), 32'd0);
    rst = 1'b0;
    n = 0;
    adv();
    chk("rst2_ready_rise", 32'(mode_ready), 32'd1);
    run_to(8);  chk("rst2_tick", 32'(step_tick), 32'd1);
    run_to(9);  chk("rst2_no_apply", 32'(cur_mode), 32'd0);
    chk("rst2_still_run", 32'(mode_ready), 32'd1);
    run_to(10); chk("rst2_leds_off", 32'(leds), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
